// File: rtl/ddr_request_arbiter_pkg.sv
// Shared types for the DDR request arbiter: FSM state encoding and the muxed
// command bundle handed to the DDR controller wrapper.
package ddr_arbiter_pkg;

  localparam int ADDR_W = 27;
  localparam int DATA_W = 64;
  localparam int MASK_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN   = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic              write;
    logic              read;
    logic              push;
    logic              pull;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data;
    logic [MASK_W-1:0] mask;
  } ddr_cmd_t;

endpackage

// File: rtl/ddr_request_arbiter_if.sv
// Bundle of requester-side and controller-side signals around the arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface ddr_request_arbiter_if #(
  parameter int REQUESTERS = 2
);
  import ddr_arbiter_pkg::*;

  logic [REQUESTERS-1:0]             req_i;
  logic [REQUESTERS-1:0]             release_i;
  logic [REQUESTERS-1:0]             read_issued_i;
  logic [REQUESTERS-1:0]             write_i;
  logic [REQUESTERS-1:0]             read_i;
  logic [REQUESTERS-1:0]             push_i;
  logic [REQUESTERS-1:0]             pull_i;
  logic [REQUESTERS-1:0][ADDR_W-1:0] address_i;
  logic [REQUESTERS-1:0][DATA_W-1:0] write_data_i;
  logic [REQUESTERS-1:0][MASK_W-1:0] write_mask_i;

  logic [REQUESTERS-1:0]             hold_o;
  logic [REQUESTERS-1:0]             read_valid_o;
  logic [REQUESTERS-1:0]             grant_o;

  logic                              ddr_write_o;
  logic                              ddr_read_o;
  logic                              ddr_push_o;
  logic                              ddr_pull_o;
  logic [ADDR_W-1:0]                 ddr_address_o;
  logic [DATA_W-1:0]                 ddr_write_data_o;
  logic [MASK_W-1:0]                 ddr_write_mask_o;
  logic                              ddr_ready_i;
  logic                              ddr_read_valid_i;

  modport slave (
    input  req_i, release_i, read_issued_i, write_i, read_i, push_i, pull_i,
    input  address_i, write_data_i, write_mask_i, ddr_ready_i, ddr_read_valid_i,
    output hold_o, read_valid_o, grant_o,
    output ddr_write_o, ddr_read_o, ddr_push_o, ddr_pull_o,
    output ddr_address_o, ddr_write_data_o, ddr_write_mask_o
  );

  modport master (
    output req_i, release_i, read_issued_i, write_i, read_i, push_i, pull_i,
    output address_i, write_data_i, write_mask_i, ddr_ready_i, ddr_read_valid_i,
    input  hold_o, read_valid_o, grant_o,
    input  ddr_write_o, ddr_read_o, ddr_push_o, ddr_pull_o,
    input  ddr_address_o, ddr_write_data_o, ddr_write_mask_o
  );

endinterface

// File: rtl/ddr_request_arbiter_picker.sv
// Round-robin picker: returns the first active request found walking circularly
// upward from rr_ptr_i, as a one-hot vector (all zero when nothing is requesting).
module rr_priority_picker #(
  parameter int N     = 2,
  parameter int PTR_W = 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] rr_ptr_i,
  output logic [N-1:0]     grant_o
);

  logic w_found;

  always_comb begin
    grant_o = '0;
    w_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!w_found && req_i[PTR_W'((int'(rr_ptr_i) + i) % N)]) begin
        grant_o[PTR_W'((int'(rr_ptr_i) + i) % N)] = 1'b1;
        w_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddr_request_arbiter.sv
// Shares one DDR user port between several cache-side requesters: round-robin
// ownership, command/data mux to DDR and read-valid steering back to the owner.
module ddr_request_arbiter
  import ddr_arbiter_pkg::*;
#(
  parameter int REQUESTERS = 2,
  parameter int READ_BEATS = 2,
  parameter int MAX_OWN    = 64
) (
  input logic             clk_i,
  input logic             rst_i,
  ddr_request_arbiter_if.slave bus
);

  localparam int PTR_W  = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
  localparam int OWN_W  = $clog2(MAX_OWN);
  localparam int BEAT_W = $clog2(READ_BEATS) + 1;
  localparam logic [OWN_W-1:0]  OWN_LAST   = OWN_W'(MAX_OWN - 1);
  localparam logic [BEAT_W-1:0] BEATS_DONE = BEAT_W'(READ_BEATS);
  localparam logic [PTR_W-1:0]  PTR_LAST   = PTR_W'(REQUESTERS - 1);

  arb_state_t              r_state, w_nextState;
  logic [REQUESTERS-1:0]   r_grant, w_pick;
  logic [PTR_W-1:0]        r_rrPtr, r_owner, w_pickIdx, w_nextPtr;
  logic [OWN_W-1:0]        r_ownCnt;
  logic [BEAT_W-1:0]       r_beatCnt;
  ddr_cmd_t                w_cmd;
  logic                    w_cmdActive;

  rr_priority_picker #(
    .N     (REQUESTERS),
    .PTR_W (PTR_W)
  ) u_picker (
    .req_i    (bus.req_i),
    .rr_ptr_i (r_rrPtr),
    .grant_o  (w_pick)
  );

  always_comb begin
    w_pickIdx = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      if (w_pick[i]) w_pickIdx = PTR_W'(i);
    end
  end

  // Owner selection uses the registered owner index only, never the live request.
  always_comb begin
    w_cmd         = '0;
    w_cmd.write   = bus.write_i[r_owner];
    w_cmd.read    = bus.read_i[r_owner];
    w_cmd.push    = bus.push_i[r_owner];
    w_cmd.pull    = bus.pull_i[r_owner];
    w_cmd.address = bus.address_i[r_owner];
    w_cmd.data    = bus.write_data_i[r_owner];
    w_cmd.mask    = bus.write_mask_i[r_owner];
  end

  assign w_cmdActive = w_cmd.write | w_cmd.read;
  assign w_nextPtr   = (r_owner == PTR_LAST) ? '0 : r_owner + PTR_W'(1);

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (bus.ddr_ready_i && |bus.req_i) w_nextState = OWN;
      end
      OWN: begin
        if (bus.read_issued_i[r_owner]) begin
          w_nextState = DRAIN;
        end else if (bus.release_i[r_owner] || !bus.req_i[r_owner] ||
                     (r_ownCnt == OWN_LAST && !w_cmdActive)) begin
          w_nextState = IDLE;
        end
      end
      DRAIN: begin
        if (r_beatCnt == BEATS_DONE && !bus.ddr_read_valid_i) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    bus.hold_o           = '1;
    bus.read_valid_o     = '0;
    bus.ddr_write_o      = 1'b0;
    bus.ddr_read_o       = 1'b0;
    bus.ddr_push_o       = 1'b0;
    bus.ddr_pull_o       = 1'b0;
    bus.ddr_address_o    = '0;
    bus.ddr_write_data_o = '0;
    bus.ddr_write_mask_o = '0;
    if (r_state == OWN || r_state == DRAIN) begin
      bus.read_valid_o[r_owner] = bus.ddr_read_valid_i;
      bus.ddr_pull_o            = w_cmd.pull;
      bus.ddr_address_o         = w_cmd.address;
      bus.ddr_write_data_o      = w_cmd.data;
      bus.ddr_write_mask_o      = w_cmd.mask;
    end
    if (r_state == OWN) begin
      bus.hold_o      = ~r_grant;
      bus.ddr_write_o = w_cmd.write;
      bus.ddr_read_o  = w_cmd.read;
      bus.ddr_push_o  = w_cmd.push;
    end
  end

  assign bus.grant_o = r_grant;

  // The forced-release counter saturates so a deferred release retries each cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_owner   <= '0;
      r_rrPtr   <= '0;
      r_ownCnt  <= '0;
      r_beatCnt <= '0;
    end else begin
      r_state <= w_nextState;
      case (r_state)
        IDLE: begin
          if (w_nextState == OWN) begin
            r_grant   <= w_pick;
            r_owner   <= w_pickIdx;
            r_ownCnt  <= '0;
            r_beatCnt <= '0;
          end
        end
        OWN: begin
          if (r_ownCnt != OWN_LAST) r_ownCnt <= r_ownCnt + OWN_W'(1);
        end
        DRAIN: begin
          if (w_cmd.pull && r_beatCnt != BEATS_DONE) r_beatCnt <= r_beatCnt + BEAT_W'(1);
        end
        default: ;
      endcase
      if (r_state != IDLE && w_nextState == IDLE) begin
        r_grant <= '0;
        r_rrPtr <= w_nextPtr;
      end
    end
  end

endmodule

// File: tb/tb_ddr_request_arbiter.sv
// Directed bench for ddr_request_arbiter with a small expected-value scoreboard
// for grants and read-valid steering.
module tb_ddr_request_arbiter;
  import ddr_arbiter_pkg::*;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  int   ownCycles;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t expQ[$];

  ddr_request_arbiter_if #(.REQUESTERS(2)) bus ();

  ddr_request_arbiter #(
    .REQUESTERS (2),
    .READ_BEATS (2),
    .MAX_OWN    (8)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic pushExpected(input string tag, input logic [63:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    expQ.push_back(e);
  endtask

  task automatic checkScoreboard(input logic [63:0] observed);
    exp_t e;
    if (expQ.size() == 0) begin
      vectors++;
      miscompares++;
      $error("[TB] FAIL scoreboard_empty observed=%0h expected=none", observed);
    end else begin
      e = expQ.pop_front();
      checkOutput(e.tag, observed, e.val);
    end
  endtask

  task automatic waitGrant(input int budget);
    int n;
    n = 0;
    while (bus.grant_o === 2'b00 && n < budget) begin
      applyStimulus(1);
      n++;
    end
    checkScoreboard(64'(bus.grant_o));
  endtask

  initial begin
    vectors          = 0;
    miscompares      = 0;
    rst              = 1'b1;
    bus.req_i        = '0;
    bus.release_i    = '0;
    bus.read_issued_i= '0;
    bus.write_i      = '0;
    bus.read_i       = '0;
    bus.push_i       = '0;
    bus.pull_i       = '0;
    bus.address_i[0] = 27'h00000AA;
    bus.address_i[1] = 27'h00000BB;
    bus.write_data_i[0] = 64'h1111_2222_3333_4444;
    bus.write_data_i[1] = 64'h5555_6666_7777_8888;
    bus.write_mask_i[0] = 8'h0F;
    bus.write_mask_i[1] = 8'hF0;
    bus.ddr_ready_i      = 1'b1;
    bus.ddr_read_valid_i = 1'b0;

    applyStimulus(2);
    checkOutput("reset_grant", 64'(bus.grant_o), 64'h0);
    checkOutput("reset_hold", 64'(bus.hold_o), 64'h3);
    checkOutput("reset_rvalid", 64'(bus.read_valid_o), 64'h0);
    checkOutput("reset_addr", 64'(bus.ddr_address_o), 64'h0);
    rst = 1'b0;
    applyStimulus(1);

    $display("[TB] both requesters contend out of reset");
    bus.req_i = 2'b11;
    pushExpected("grant_first", 64'h1);
    waitGrant(3);
    checkOutput("hold_owner0", 64'(bus.hold_o), 64'h2);
    checkOutput("addr_owner0", 64'(bus.ddr_address_o), 64'h0AA);
    checkOutput("mask_owner0", 64'(bus.ddr_write_mask_o), 64'h0F);

    $display("[TB] non-owner write ignored");
    bus.address_i[1] = 27'h0001234;
    bus.write_i      = 2'b10;
    #1;
    checkOutput("nonowner_write", 64'(bus.ddr_write_o), 64'h0);
    checkOutput("nonowner_addr", 64'(bus.ddr_address_o), 64'h0AA);

    bus.write_i   = 2'b01;
    bus.release_i = 2'b01;
    pushExpected("grant_after_release", 64'h2);
    #1;
    checkOutput("write_with_release", 64'(bus.ddr_write_o), 64'h1);
    applyStimulus(1);
    bus.write_i   = '0;
    bus.release_i = '0;
    checkOutput("idle_after_release", 64'(bus.grant_o), 64'h0);
    waitGrant(3);
    checkOutput("hold_owner1", 64'(bus.hold_o), 64'h1);
    checkOutput("addr_owner1", 64'(bus.ddr_address_o), 64'h1234);

    $display("[TB] owner 1 read burst, release and read_issued together");
    bus.read_i        = 2'b10;
    bus.read_issued_i = 2'b10;
    bus.release_i     = 2'b10;
    #1;
    checkOutput("read_strobe", 64'(bus.ddr_read_o), 64'h1);
    applyStimulus(1);
    bus.read_i        = '0;
    bus.read_issued_i = '0;
    bus.release_i     = '0;
    checkOutput("drain_grant", 64'(bus.grant_o), 64'h2);
    checkOutput("drain_hold", 64'(bus.hold_o), 64'h3);
    for (int b = 0; b < 2; b++) begin
      bus.ddr_read_valid_i = 1'b1;
      bus.pull_i           = 2'b10;
      pushExpected($sformatf("rvalid_beat%0d", b), 64'h2);
      #1;
      checkScoreboard(64'(bus.read_valid_o));
      checkOutput($sformatf("pull_beat%0d", b), 64'(bus.ddr_pull_o), 64'h1);
      applyStimulus(1);
    end
    bus.ddr_read_valid_i = 1'b0;
    bus.pull_i           = '0;
    #1;
    checkOutput("rvalid_after_beats", 64'(bus.read_valid_o), 64'h0);
    checkOutput("still_drain", 64'(bus.grant_o), 64'h2);
    applyStimulus(1);
    checkOutput("idle_after_drain", 64'(bus.grant_o), 64'h0);
    pushExpected("grant_after_drain", 64'h1);
    waitGrant(3);

    $display("[TB] requester 0 hogs the port");
    ownCycles = 1;
    for (int c = 0; c < 20; c++) begin
      applyStimulus(1);
      if (bus.grant_o !== 2'b01) break;
      ownCycles++;
    end
    checkOutput("own_cycles", 64'(ownCycles), 64'd8);
    pushExpected("grant_after_force", 64'h2);
    waitGrant(3);

    bus.req_i = 2'b00;
    applyStimulus(1);
    checkOutput("idle_no_req", 64'(bus.grant_o), 64'h0);

    $display("[TB] controller not ready");
    bus.ddr_ready_i = 1'b0;
    bus.req_i       = 2'b01;
    applyStimulus(3);
    checkOutput("notready_grant", 64'(bus.grant_o), 64'h0);
    checkOutput("notready_hold", 64'(bus.hold_o), 64'h3);
    bus.ddr_ready_i = 1'b1;
    applyStimulus(1);
    checkOutput("ready_grant", 64'(bus.grant_o), 64'h1);

    $display("[TB] reset in the middle of a burst");
    bus.read_issued_i = 2'b01;
    applyStimulus(1);
    bus.read_issued_i    = '0;
    bus.ddr_read_valid_i = 1'b1;
    bus.pull_i           = 2'b01;
    #1;
    checkOutput("midburst_rvalid", 64'(bus.read_valid_o), 64'h1);
    applyStimulus(1);
    rst = 1'b1;
    applyStimulus(1);
    checkOutput("rst_grant", 64'(bus.grant_o), 64'h0);
    checkOutput("rst_hold", 64'(bus.hold_o), 64'h3);
    checkOutput("rst_rvalid", 64'(bus.read_valid_o), 64'h0);
    checkOutput("rst_pull", 64'(bus.ddr_pull_o), 64'h0);
    checkOutput("rst_addr", 64'(bus.ddr_address_o), 64'h0);
    rst                  = 1'b0;
    bus.ddr_read_valid_i = 1'b0;
    bus.pull_i           = '0;
    bus.req_i            = '0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
